// File: rtl/vc_output_port.sv
// Per-output port of the gold router: two virtual-channel FIFOs, each fed by an
// NUM_IN-way round-robin arbiter, drained onto the link in the matching polarity phase.

module vc_rr_arb #(
  parameter int NUM_IN = 4,
  parameter int IDXW   = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              enable,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDXW-1:0]   last_gnt
);

  logic            found;
  logic [IDXW-1:0] sel;

  // Search begins one past the last winner so the previous grantee goes last.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sel   = last_gnt;
    for (int k = 1; k <= NUM_IN; k++) begin
      int idx;
      idx = (int'(last_gnt) + k) % NUM_IN;
      if (!found && enable && req[idx]) begin
        gnt[idx] = 1'b1;
        sel      = IDXW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= IDXW'(NUM_IN - 1);
    end else if (found) begin
      last_gnt <= sel;
    end
  end

endmodule

module vc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCCW-1:0]  occ
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

endmodule

module vc_output_port #(
  parameter int PACKET_SIZE = 64,
  parameter int NUM_IN      = 4,
  parameter int DEPTH       = 2,
  parameter int IDXW        = $clog2(NUM_IN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          polarity,
  input  logic [NUM_IN-1:0]             si,
  input  logic [NUM_IN*PACKET_SIZE-1:0] di,
  output logic [NUM_IN-1:0]             ri,
  output logic                          so,
  input  logic                          ro,
  output logic [PACKET_SIZE-1:0]        dout,
  output logic [IDXW-1:0]               debug_last_gnt_v0,
  output logic [IDXW-1:0]               debug_last_gnt_v1,
  output logic [$clog2(DEPTH+1)-1:0]    occ_v0,
  output logic [$clog2(DEPTH+1)-1:0]    occ_v1
);

  localparam int OCCW = $clog2(DEPTH + 1);

  logic [NUM_IN-1:0]      req_v0;
  logic [NUM_IN-1:0]      req_v1;
  logic [NUM_IN-1:0]      gnt_v0;
  logic [NUM_IN-1:0]      gnt_v1;
  logic                   space_v0;
  logic                   space_v1;
  logic                   push_v0;
  logic                   push_v1;
  logic                   pop_v0;
  logic                   pop_v1;
  logic [PACKET_SIZE-1:0] din_v0;
  logic [PACKET_SIZE-1:0] din_v1;
  logic [PACKET_SIZE-1:0] head_v0;
  logic [PACKET_SIZE-1:0] head_v1;

  always_comb begin
    req_v0 = '0;
    req_v1 = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      req_v0[i] = si[i] & ~di[i*PACKET_SIZE + PACKET_SIZE - 1];
      req_v1[i] = si[i] &  di[i*PACKET_SIZE + PACKET_SIZE - 1];
    end
  end

  // Fullness is judged on the registered count only; a same-edge pop does not free a slot.
  assign space_v0 = occ_v0 < OCCW'(DEPTH);
  assign space_v1 = occ_v1 < OCCW'(DEPTH);

  vc_rr_arb #(.NUM_IN(NUM_IN), .IDXW(IDXW)) u_arb_v0 (
    .clk      (clk),
    .reset    (reset),
    .req      (req_v0),
    .enable   (reset & space_v0),
    .gnt      (gnt_v0),
    .last_gnt (debug_last_gnt_v0)
  );

  vc_rr_arb #(.NUM_IN(NUM_IN), .IDXW(IDXW)) u_arb_v1 (
    .clk      (clk),
    .reset    (reset),
    .req      (req_v1),
    .enable   (reset & space_v1),
    .gnt      (gnt_v1),
    .last_gnt (debug_last_gnt_v1)
  );

  assign ri      = gnt_v0 | gnt_v1;
  assign push_v0 = |gnt_v0;
  assign push_v1 = |gnt_v1;

  always_comb begin
    din_v0 = '0;
    din_v1 = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_v0[i]) din_v0 = di[i*PACKET_SIZE +: PACKET_SIZE];
      if (gnt_v1[i]) din_v1 = di[i*PACKET_SIZE +: PACKET_SIZE];
    end
  end

  assign pop_v0 = ro & ~polarity & (occ_v0 != '0);
  assign pop_v1 = ro &  polarity & (occ_v1 != '0);

  vc_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(DEPTH), .OCCW(OCCW)) u_fifo_v0 (
    .clk   (clk),
    .reset (reset),
    .push  (push_v0),
    .din   (din_v0),
    .pop   (pop_v0),
    .head  (head_v0),
    .occ   (occ_v0)
  );

  vc_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(DEPTH), .OCCW(OCCW)) u_fifo_v1 (
    .clk   (clk),
    .reset (reset),
    .push  (push_v1),
    .din   (din_v1),
    .pop   (pop_v1),
    .head  (head_v1),
    .occ   (occ_v1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      so   <= 1'b0;
      dout <= '0;
    end else begin
      so <= pop_v0 | pop_v1;
      if (pop_v0) begin
        dout <= head_v0;
      end else if (pop_v1) begin
        dout <= head_v1;
      end
    end
  end

endmodule

// File: tb/tb_vc_output_port.sv
// Directed bench for vc_output_port: reset, round-robin order, dual-VC phases,
// backpressure with full FIFO, and asynchronous reset mid-operation.

module tb_vc_output_port;

  localparam int PS = 64;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int IW = 2;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          polarity = 1'b0;
  logic          ro = 1'b0;
  logic [N-1:0]  si = '0;
  logic [N*PS-1:0] di = '0;
  logic [N-1:0]  ri;
  logic          so;
  logic [PS-1:0] dout;
  logic [IW-1:0] lg0;
  logic [IW-1:0] lg1;
  logic [OW-1:0] occ0;
  logic [OW-1:0] occ1;

  int checks = 0;
  int errors = 0;

  vc_output_port #(.PACKET_SIZE(PS), .NUM_IN(N), .DEPTH(D)) dut (
    .clk               (clk),
    .reset             (reset),
    .polarity          (polarity),
    .si                (si),
    .di                (di),
    .ri                (ri),
    .so                (so),
    .ro                (ro),
    .dout              (dout),
    .debug_last_gnt_v0 (lg0),
    .debug_last_gnt_v1 (lg1),
    .occ_v0            (occ0),
    .occ_v1            (occ1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_di(input int i, input logic [PS-1:0] p);
    di[i*PS +: PS] = p;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    si = '0;
    di = '0;
    ro = 1'b0;
    polarity = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    // 1: reset state, then single VC0 packet
    si = 4'b0001;
    set_di(0, 64'h0000_0002_0001_0002);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_so", so, 0);
    chk("rst_dout", dout, 0);
    chk("rst_occ0", occ0, 0);
    chk("rst_occ1", occ1, 0);
    chk("rst_lg0", lg0, 3);
    chk("rst_lg1", lg1, 3);
    chk("rst_ri", ri, 0);
    reset = 1'b1;
    polarity = 1'b1;
    ro = 1'b1;
    #1 chk("t1_ri", ri, 4'b0001);
    step();
    chk("t1_lg0", lg0, 0);
    chk("t1_occ_push", occ0, 1);
    chk("t1_so_wrongphase", so, 0);
    si = '0;
    polarity = 1'b0;
    step();
    chk("t1_so", so, 1);
    chk("t1_dout", dout, 64'h0000_0002_0001_0002);
    chk("t1_occ_pop", occ0, 0);
    polarity = 1'b1;
    step();
    chk("t1_so_idle", so, 0);
    chk("t1_dout_hold", dout, 64'h0000_0002_0001_0002);

    // 2: round-robin fairness on VC0
    do_reset();
    for (int i = 0; i < N; i++) set_di(i, 64'h100 + 64'(i));
    si = 4'b1111;
    #1 chk("t2_ri_a", ri, 4'b0001);
    step();
    si[0] = 1'b0;
    #1 chk("t2_ri_b", ri, 4'b0010);
    chk("t2_occ_a", occ0, 1);
    step();
    si[1] = 1'b0;
    #1 chk("t2_ri_full", ri, 4'b0000);
    chk("t2_occ_full", occ0, 2);
    chk("t2_lg_b", lg0, 1);
    ro = 1'b1;
    #1 chk("t2_ri_full_pop", ri, 4'b0000);
    step();
    chk("t2_so_p0", so, 1);
    chk("t2_dout_p0", dout, 64'h100);
    chk("t2_occ_p0", occ0, 1);
    si[0] = 1'b1;
    set_di(0, 64'h104);
    polarity = 1'b1;
    #1 chk("t2_ri_2", ri, 4'b0100);
    step();
    chk("t2_so_odd", so, 0);
    chk("t2_occ_2", occ0, 2);
    chk("t2_lg_2", lg0, 2);
    si[2] = 1'b0;
    polarity = 1'b0;
    #1 chk("t2_ri_full2", ri, 4'b0000);
    step();
    chk("t2_dout_p1", dout, 64'h101);
    chk("t2_occ_p1", occ0, 1);
    #1 chk("t2_ri_3", ri, 4'b1000);
    step();
    chk("t2_dout_p2", dout, 64'h102);
    chk("t2_lg_3", lg0, 3);
    chk("t2_occ_3", occ0, 1);
    si[3] = 1'b0;
    #1 chk("t2_ri_0", ri, 4'b0001);
    step();
    chk("t2_dout_p3", dout, 64'h103);
    chk("t2_lg_0", lg0, 0);
    si = '0;
    step();
    chk("t2_dout_p4", dout, 64'h104);
    chk("t2_occ_end", occ0, 0);

    // 3: dual-VC concurrency, phase-gated drain
    do_reset();
    polarity = 1'b1;
    si = 4'b0110;
    set_di(1, 64'h0000_0000_0000_AAAA);
    set_di(2, 64'h8000_0000_0000_BBBB);
    #1 chk("t3_ri_dual", ri, 4'b0110);
    step();
    chk("t3_occ0", occ0, 1);
    chk("t3_occ1", occ1, 1);
    chk("t3_lg0", lg0, 1);
    chk("t3_lg1", lg1, 2);
    si = '0;
    ro = 1'b1;
    step();
    chk("t3_so_b", so, 1);
    chk("t3_dout_b", dout, 64'h8000_0000_0000_BBBB);
    chk("t3_occ0_kept", occ0, 1);
    step();
    chk("t3_so_none", so, 0);
    chk("t3_occ0_still", occ0, 1);
    polarity = 1'b0;
    step();
    chk("t3_so_a", so, 1);
    chk("t3_dout_a", dout, 64'h0000_0000_0000_AAAA);

    // 4+5: backpressure, full FIFO with simultaneous pop
    do_reset();
    si = 4'b0001;
    set_di(0, 64'h401);
    #1 chk("t4_ri_q0", ri, 4'b0001);
    step();
    set_di(0, 64'h402);
    #1 chk("t4_ri_q1", ri, 4'b0001);
    step();
    set_di(0, 64'h403);
    for (int c = 0; c < 4; c++) begin
      #1 chk("t4_ri_blocked", ri, 4'b0000);
      chk("t4_occ_sat", occ0, 2);
      step();
    end
    ro = 1'b1;
    #1 chk("t5_ri_full_pop", ri, 4'b0000);
    step();
    chk("t5_dout_q0", dout, 64'h401);
    chk("t5_occ_after_pop", occ0, 1);
    #1 chk("t5_ri_accept", ri, 4'b0001);
    step();
    chk("t5_dout_q1", dout, 64'h402);
    chk("t5_occ_pushpop", occ0, 1);
    si = '0;
    step();
    chk("t4_dout_q2", dout, 64'h403);
    chk("t4_occ_end", occ0, 0);

    // 6: asynchronous reset with both VCs holding a packet
    do_reset();
    si = 4'b0011;
    set_di(0, 64'h600);
    set_di(1, 64'h8000_0000_0000_0601);
    #1 chk("t6_ri_dual", ri, 4'b0011);
    step();
    si[1] = 1'b0;
    set_di(0, 64'h602);
    step();
    si = '0;
    ro = 1'b1;
    step();
    chk("t6_pre_dout", dout, 64'h600);
    chk("t6_pre_occ0", occ0, 1);
    chk("t6_pre_occ1", occ1, 1);
    si = 4'b0001;
    #2 reset = 1'b0;
    #1;
    chk("t6_so", so, 0);
    chk("t6_dout", dout, 0);
    chk("t6_occ0", occ0, 0);
    chk("t6_occ1", occ1, 0);
    chk("t6_ri", ri, 0);
    si = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      polarity = c[0];
      step();
      chk("t6_no_stale", so, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_output_port.md
Name: vc_output_port

Overview:
- Parametrised output port for the gold router family. It replaces the fixed 2-input arbiter per output with an NUM_IN-way round-robin arbiter per virtual channel (VC), plus a DEPTH-entry FIFO per VC.
- Packets are drained onto the outgoing link only in the polarity phase that matches their VC.
- One instance sits behind each router output direction (cw, ccw, ns, sn, pe).

Parameters:
- PACKET_SIZE, 64, packet width in bits; bit PACKET_SIZE-1 is the VC bit.
- NUM_IN, 4, number of requesting input ports (2..8).
- DEPTH, 2, entries per VC FIFO (1..8).
- IDXW, $clog2(NUM_IN), width of grant index.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- polarity  input  1  network phase; 0 = even phase drains VC0, 1 = odd phase drains VC1.
- si  input  NUM_IN  per-input send request.
- di  input  NUM_IN*PACKET_SIZE  per-input packet; input i occupies bits [i*PACKET_SIZE +: PACKET_SIZE].
- ri  output  NUM_IN  per-input ready/grant (combinational).
- so  output  1  outgoing send strobe (registered).
- ro  input  1  downstream ready.
- dout  output  PACKET_SIZE  outgoing packet (registered).
- debug_last_gnt_v0  output  IDXW  index of last input granted on VC0.
- debug_last_gnt_v1  output  IDXW  index of last input granted on VC1.
- occ_v0  output  $clog2(DEPTH+1)  VC0 FIFO occupancy.
- occ_v1  output  $clog2(DEPTH+1)  VC1 FIFO occupancy.

Behaviour:
- Reset (reset=0, async):
  - so=0, dout=0, both FIFOs empty, occ_v*=0.
  - debug_last_gnt_v0 = debug_last_gnt_v1 = NUM_IN-1, so input 0 has first priority.
  - ri=0 while reset=0.
  - Reset mid-operation discards all buffered packets; no partial transfer completes.
- Request classification:
  - Input i requests VCv when si[i]=1 and di_i[PACKET_SIZE-1]=v.
  - A VC is eligible to accept only if its registered occupancy is < DEPTH. Fullness is taken from the start-of-cycle count; there is no same-cycle pop bypass.
- Arbitration:
  - Independent per VC, round-robin. Search starts at last_gnt_v+1 mod NUM_IN and takes the first requesting input.
  - At most one grant per VC per cycle, so up to 2 grants total; the two are always on different inputs.
  - ri[i]=1 only for a granted input. ri is combinational from si, di, occupancy and last_gnt.
- Handshake (input side):
  - A transfer occurs at the rising edge where si[i]&ri[i]=1. The packet is pushed onto its VC FIFO and debug_last_gnt_v updates to i at that edge.
  - Upstream holds si/di stable until it sees ri=1.
  - A non-granted requester keeps priority order; last_gnt changes only on a grant.
- Drain (output side):
  - At each rising edge, with p = polarity sampled at that edge: if ro=1 and FIFO p is non-empty, then so<=1, dout<=head of FIFO p, and FIFO p pops. Otherwise so<=0 and dout holds its value.
  - The FIFO of the other VC never drains in that cycle.
- Simultaneous push and pop on the same VC:
  - Allowed when occupancy < DEPTH; occupancy stays unchanged.
  - When occupancy == DEPTH, the push is blocked (ri=0) even if a pop occurs that edge.
- Ordering: each VC FIFO is strict FIFO; wrap-around of the read/write pointers at DEPTH is transparent.
- Latency: a push at edge N to an empty VC FIFO can appear on so/dout at edge N+1 at the earliest, provided polarity matches and ro=1 at N+1.
- Packet contents pass through unmodified (no hop decrement in this block).

Test Plan:
1. Reset then single push: reset low 3 cycles, release; si[0]=1, di_0=0x0000_0002_0001_0002 (VC0). Required: ri[0]=1 first cycle, debug_last_gnt_v0=0; so=1 with dout equal to the packet on the first edge with polarity=0 and ro=1; occ_v0 returns to 0.
2. Round-robin fairness: NUM_IN=4, all inputs hold VC0 requests, ro=0. Required: grants in order 0,1 (FIFO full at DEPTH=2, ri all 0 afterwards). Then ro=1 with polarity toggling: remaining grants go 2, 3, 0 as space frees; no input is granted twice before all waiting inputs are served.
3. Dual-VC concurrency: si[1]=1 with VC0 packet 0x0..AAAA, si[2]=1 with VC1 packet 0x8..BBBB, same cycle. Required: ri[1]=ri[2]=1 simultaneously; AAAA exits only in a polarity=0 cycle and BBBB only in a polarity=1 cycle.
4. Backpressure/full: ro=0 for 6 cycles while input 0 streams 3 VC0 packets. Required: occ_v0 saturates at 2, third packet sees ri[0]=0 until ro=1 and a pop occurs, then accepted one cycle later; output order is preserved.
5. Full plus simultaneous pop: occ_v0=2, polarity=0, ro=1, new VC0 request. Required: the pop happens but the request is not accepted that edge (ri=0); it is accepted the next cycle; occ_v0 goes 2→1→1.
6. Reset mid-operation: both FIFOs hold 1 packet, assert reset=0 asynchronously between edges. Required: so=0, dout=0, occ_v0=occ_v1=0 immediately; after release no stale packet is ever emitted.
